// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the external memory port arbiter: owner/state encodings
// and the registered command that drives the memory bus.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_LD,
    OWN_SR
  } arb_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              rnw;
    logic              sdram;
  } ram_cmd_t;

endpackage

// File: rtl/ram_port_arbiter_select.sv
// Combinational priority/starvation decision for the memory port.
// The SR requester only competes when RAM_ARB_SRAM_EN is defined.
module ram_arb_select
  import ram_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic             ld_lock,
  input  logic             ld_req,
  input  logic             cpu_req,
  input  logic             sr_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output arb_owner_t       winner
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block leaves a value unassigned and a latch is never inferred.
  always_comb begin
    winner = OWN_NONE;
    if (ld_lock) begin
      if (ld_req) winner = OWN_LD;
    end else begin
`ifdef RAM_ARB_SRAM_EN
      if (sr_req && (starve_cnt >= STARVE_LIM || !cpu_req)) winner = OWN_SR;
      else if (cpu_req)                                       winner = OWN_CPU;
      else if (ld_req)                                        winner = OWN_LD;
`else
      if (cpu_req)     winner = OWN_CPU;
      else if (ld_req) winner = OWN_LD;
`endif
    end
  end

`ifndef RAM_ARB_SRAM_EN
  logic sel_unused;
  assign sel_unused = ^{sr_req, starve_cnt};
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one external memory port between the CPU, the ROM loader and the
// SRAM save/load engine (SR port present only with RAM_ARB_SRAM_EN).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4,
  parameter int STARVE_MAX    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_rnw,
  input  logic              cpu_sdram,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_wait_n,
  input  logic              ld_lock,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_din,
  output logic              ld_ack,
  input  logic              sr_req,
  input  logic [ADDR_W-1:0] sr_addr,
  input  logic [DATA_W-1:0] sr_din,
  input  logic              sr_rnw,
  output logic              sr_ack,
  output logic [DATA_W-1:0] sr_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_rnw,
  output logic              sdram_ce,
  output logic              bram_ce,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam ram_cmd_t         CMD_RESET  = '{addr: '0, din: '0, rnw: 1'b1, sdram: 1'b0};

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  ram_cmd_t          cmd_q, cmd_d, win_cmd;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sdram_ce_q, sdram_ce_d, bram_ce_q, bram_ce_d;
  logic              cpu_ack_q, cpu_ack_d, ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [CNT_W-1:0]  starve_cnt;
  arb_owner_t        win;
  logic              access_end;

  ram_arb_select #(.STARVE_MAX(STARVE_MAX)) u_select (
    .ld_lock    (ld_lock),
    .ld_req     (ld_req),
    .cpu_req    (cpu_req),
    .sr_req     (sr_req),
    .starve_cnt (starve_cnt),
    .winner     (win)
  );

  assign access_end = (state_q == ARB_ACCESS) && (cnt_q == '0);

  // Loader traffic is always an SDRAM write; SR traffic always targets BRAM.
  always_comb begin
    win_cmd = cmd_q;
    case (win)
      OWN_CPU: win_cmd = '{addr: cpu_addr, din: cpu_din, rnw: cpu_rnw, sdram: cpu_sdram};
      OWN_LD:  win_cmd = '{addr: ld_addr, din: ld_din, rnw: 1'b0, sdram: 1'b1};
`ifdef RAM_ARB_SRAM_EN
      OWN_SR:  win_cmd = '{addr: sr_addr, din: sr_din, rnw: sr_rnw, sdram: 1'b0};
`endif
      default: win_cmd = cmd_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    sdram_ce_d = sdram_ce_q;
    bram_ce_d  = bram_ce_q;
    cpu_ack_d  = 1'b0;
    ld_ack_d   = 1'b0;
    cpu_dout_d = cpu_dout_q;
    case (state_q)
      ARB_IDLE: begin
        if (win != OWN_NONE) begin
          state_d    = ARB_ACCESS;
          owner_d    = win;
          cmd_d      = win_cmd;
          cnt_d      = CNT_LOAD;
          sdram_ce_d = win_cmd.sdram;
          bram_ce_d  = ~win_cmd.sdram;
        end
      end
      ARB_ACCESS: begin
        if (access_end) begin
          state_d    = ARB_DONE;
          sdram_ce_d = 1'b0;
          bram_ce_d  = 1'b0;
          cpu_ack_d  = (owner_q == OWN_CPU);
          ld_ack_d   = (owner_q == OWN_LD);
          if (owner_q == OWN_CPU && cmd_q.rnw) cpu_dout_d = ram_dout;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_NONE;
      cmd_q      <= CMD_RESET;
      cnt_q      <= '0;
      sdram_ce_q <= 1'b0;
      bram_ce_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      ld_ack_q   <= 1'b0;
      cpu_dout_q <= 8'hFF;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      sdram_ce_q <= sdram_ce_d;
      bram_ce_q  <= bram_ce_d;
      cpu_ack_q  <= cpu_ack_d;
      ld_ack_q   <= ld_ack_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

`ifdef RAM_ARB_SRAM_EN
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              sr_ack_q, sr_ack_d;
  logic [DATA_W-1:0] sr_dout_q, sr_dout_d;

  // Counts CPU wins while SR waits; SR is forced through once it saturates.
  always_comb begin
    starve_d  = starve_q;
    sr_ack_d  = 1'b0;
    sr_dout_d = sr_dout_q;
    if (state_q == ARB_IDLE) begin
      if (!sr_req || win == OWN_SR)                        starve_d = '0;
      else if (win == OWN_CPU && starve_q < STARVE_LIM)    starve_d = starve_q + 4'd1;
    end
    if (access_end && owner_q == OWN_SR) begin
      sr_ack_d = 1'b1;
      if (cmd_q.rnw) sr_dout_d = ram_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q  <= '0;
      sr_ack_q  <= 1'b0;
      sr_dout_q <= 8'hFF;
    end else begin
      starve_q  <= starve_d;
      sr_ack_q  <= sr_ack_d;
      sr_dout_q <= sr_dout_d;
    end
  end

  assign starve_cnt = starve_q;
  assign sr_ack     = sr_ack_q;
  assign sr_dout    = sr_dout_q;
`else
  logic sr_unused;
  assign sr_unused  = ^{sr_addr, sr_din, sr_rnw};
  assign starve_cnt = '0;
  assign sr_ack     = 1'b0;
  assign sr_dout    = 8'hFF;
`endif

  assign ram_addr   = cmd_q.addr;
  assign ram_din    = cmd_q.din;
  assign ram_rnw    = cmd_q.rnw;
  assign sdram_ce   = sdram_ce_q;
  assign bram_ce    = bram_ce_q;
  assign cpu_ack    = cpu_ack_q;
  assign ld_ack     = ld_ack_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_wait_n = ~(cpu_req & ~cpu_ack_q);

endmodule
